// File: rtl/bus_demux3_pkg.sv
// bus_demux3_pkg: shared state, target-index types and constants for the 3-target data-bus router
package bus_demux3_pkg;
  localparam int NUM_TARGETS = 3;
  typedef logic [1:0] tgt_t;
  localparam tgt_t TGT_NONE = 2'd3;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
  function automatic logic [NUM_TARGETS-1:0] tgt_onehot(input tgt_t t);
    return (t == TGT_NONE) ? '0 : NUM_TARGETS'(1) << t;
  endfunction
endpackage

// File: rtl/addr_decoder3.sv
// addr_decoder3: combinational region decode, lower region index wins on overlap
module addr_decoder3
  import bus_demux3_pkg::*;
#(
  parameter int                      P_ADDR_WIDTH = 32,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE0      = 32'h0000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK0      = 32'hFFFF_C000,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE1      = 32'h1000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK1      = 32'hFFFF_FF00,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE2      = 32'h2000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK2      = 32'hFFFF_FFF0
) (
  input  logic [P_ADDR_WIDTH-1:0] i_addr,
  output tgt_t                    o_tgt,
  output logic                    o_hit
);
  logic [NUM_TARGETS-1:0] match;
  assign match = {(i_addr & P_MASK2) == P_BASE2,
                  (i_addr & P_MASK1) == P_BASE1,
                  (i_addr & P_MASK0) == P_BASE0};
  assign o_tgt = match[0] ? 2'd0 : match[1] ? 2'd1 : match[2] ? 2'd2 : TGT_NONE;
  assign o_hit = |match;
endmodule

// File: rtl/bus_demux3.sv
// bus_demux3: 1-initiator to 3-target load/store router, one outstanding transaction.
// Optional response timeout enabled by defining BUS_TIMEOUT_EN.
module bus_demux3
  import bus_demux3_pkg::*;
#(
  parameter int                      P_ADDR_WIDTH     = 32,
  parameter int                      P_DATA_WIDTH     = 32,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE0          = 32'h0000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK0          = 32'hFFFF_C000,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE1          = 32'h1000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK1          = 32'hFFFF_FF00,
  parameter logic [P_ADDR_WIDTH-1:0] P_BASE2          = 32'h2000_0000,
  parameter logic [P_ADDR_WIDTH-1:0] P_MASK2          = 32'hFFFF_FFF0,
  parameter int                      P_TIMEOUT_CYCLES = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic [P_ADDR_WIDTH-1:0]             i_req_addr,
  input  logic                                i_req_we,
  input  logic [P_DATA_WIDTH-1:0]             i_req_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]           i_req_be,
  output logic                                o_rsp_valid,
  output logic [P_DATA_WIDTH-1:0]             o_rsp_rdata,
  output logic                                o_rsp_err,
  output logic [NUM_TARGETS-1:0]              o_t_valid,
  input  logic [NUM_TARGETS-1:0]              i_t_ready,
  output logic [P_ADDR_WIDTH-1:0]             o_t_addr,
  output logic                                o_t_we,
  output logic [P_DATA_WIDTH-1:0]             o_t_wdata,
  output logic [P_DATA_WIDTH/8-1:0]           o_t_be,
  input  logic [NUM_TARGETS-1:0]              i_t_rsp_valid,
  input  logic [NUM_TARGETS*P_DATA_WIDTH-1:0] i_t_rdata
);
  localparam int BW = P_DATA_WIDTH / 8;
  state_t                  state_q, state_d;
  tgt_t                    sel_q, sel_d, dec_tgt;
  logic                    dec_hit, timeout;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    we_q, we_d, err_q, err_d;
  logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BW-1:0]           be_q, be_d;

  addr_decoder3 #(
    .P_ADDR_WIDTH(P_ADDR_WIDTH),
    .P_BASE0(P_BASE0), .P_MASK0(P_MASK0),
    .P_BASE1(P_BASE1), .P_MASK1(P_MASK1),
    .P_BASE2(P_BASE2), .P_MASK2(P_MASK2)
  ) u_dec (
    .i_addr(i_req_addr),
    .o_tgt (dec_tgt),
    .o_hit (dec_hit)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy;
  assign busy    = (state_q == ISSUE) || (state_q == WAIT);
  // counter is zero in IDLE, so it is already cleared at acceptance
  assign cnt_d   = busy ? cnt_q + 1'b1 : '0;
  assign timeout = busy && (cnt_d == CW'(P_TIMEOUT_CYCLES));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |P_TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_req_valid) begin
        sel_d   = dec_tgt;
        addr_d  = i_req_addr;
        we_d    = i_req_we;
        wdata_d = i_req_wdata;
        be_d    = i_req_be;
        state_d = dec_hit ? ISSUE : ERR;
      end
      ISSUE:   state_d = i_t_ready[sel_q] ? WAIT : ISSUE;
      WAIT:    state_d = i_t_rsp_valid[sel_q] ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = ERR;
    // RESP and ERR are only ever entered, never held, so these fire once per response
    if (state_d == RESP) begin
      rdata_d = we_q ? '0 : i_t_rdata[sel_q*P_DATA_WIDTH +: P_DATA_WIDTH];
      err_d   = 1'b0;
    end
    if (state_d == ERR) begin
      rdata_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end

  assign o_req_ready = state_q == IDLE;
  assign o_t_valid   = (state_q == ISSUE) ? tgt_onehot(sel_q) : '0;
  assign o_t_addr    = addr_q;
  assign o_t_we      = we_q;
  assign o_t_wdata   = wdata_q;
  assign o_t_be      = be_q;
  assign o_rsp_valid = (state_q == RESP) || (state_q == ERR);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
endmodule

// File: tb/tb_bus_demux3.sv
// tb_bus_demux3: table-driven, randomized and hand-sequenced checks of bus_demux3
module tb_bus_demux3;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_we;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_be;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [2:0]  o_t_valid;
  logic [2:0]  i_t_ready;
  logic [31:0] o_t_addr;
  logic        o_t_we;
  logic [31:0] o_t_wdata;
  logic [3:0]  o_t_be;
  logic [2:0]  i_t_rsp_valid;
  logic [95:0] i_t_rdata;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdly;
    int          sdly;
    logic [31:0] rdata;
    logic        stray;
    int          exp_tgt;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[11];

  bus_demux3 #(.P_TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_we(i_req_we),
    .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_t_valid(o_t_valid), .i_t_ready(i_t_ready),
    .o_t_addr(o_t_addr), .o_t_we(o_t_we), .o_t_wdata(o_t_wdata), .o_t_be(o_t_be),
    .i_t_rsp_valid(i_t_rsp_valid), .i_t_rdata(i_t_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_tgt(input logic [31:0] a);
    if (a < 32'h0000_4000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_0100) return 1;
    if (a >= 32'h2000_0000 && a < 32'h2000_0010) return 2;
    return 3;
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic [3:0] be, input int rdly, input int sdly,
                              input logic [31:0] rdata, input logic stray, input int exp_tgt,
                              input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.addr = addr; v.we = we; v.wdata = wdata; v.be = be; v.rdly = rdly; v.sdly = sdly;
    v.rdata = rdata; v.stray = stray; v.exp_tgt = exp_tgt; v.exp_lat = exp_lat;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    logic [31:0] base;
    int          r;
    r    = $urandom_range(0, 4);
    base = (r == 0) ? 32'h0 : (r == 1) ? 32'h1000_0000 : (r == 2) ? 32'h2000_0000 : 32'h3000_0000;
    v.addr  = (r == 4) ? 32'($urandom) :
              base + 32'($urandom_range(0, (r == 0) ? 32'h8000 : (r == 1) ? 32'h200 : 32'h20));
    v.we    = 1'($urandom);
    v.wdata = $urandom;
    v.be    = 4'($urandom);
    v.rdly  = $urandom_range(0, 3);
    v.sdly  = $urandom_range(0, 3);
    v.rdata = $urandom;
    v.stray = 1'($urandom);
    v.exp_tgt   = ref_tgt(v.addr);
    v.exp_lat   = (v.exp_tgt == 3) ? 1 : 3 + v.rdly + v.sdly;
    v.exp_err   = v.exp_tgt == 3;
    v.exp_rdata = (v.exp_tgt == 3 || v.we) ? 32'h0 : v.rdata;
    return v;
  endfunction

  // Starts and ends on a falling edge with the DUT idle; acts as all three targets.
  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0]  m, sel_rv;
    logic [95:0] rd;
    logic        issuing;
    m = (v.exp_tgt < 3) ? 3'(1 << v.exp_tgt) : 3'b000;
    chk($sformatf("%s req_ready idle", tag), 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_addr = v.addr; i_req_we = v.we;
    i_req_wdata = v.wdata; i_req_be = v.be;
    i_t_ready = 3'($urandom); i_t_rsp_valid = 3'($urandom);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_addr = $urandom; i_req_we = 1'($urandom);
    i_req_wdata = $urandom; i_req_be = 4'($urandom);
    for (int c = 1; c <= v.exp_lat; c++) begin
      issuing = (m != 0) && (c <= 1 + v.rdly);
      chk($sformatf("%s c%0d t_valid", tag, c), 32'(o_t_valid), issuing ? 32'(m) : 32'd0);
      chk($sformatf("%s c%0d rsp_valid", tag, c), 32'(o_rsp_valid), 32'(c == v.exp_lat));
      chk($sformatf("%s c%0d req_ready", tag, c), 32'(o_req_ready), 32'd0);
      if (issuing) begin
        chk($sformatf("%s c%0d t_addr", tag, c), o_t_addr, v.addr);
        chk($sformatf("%s c%0d t_we", tag, c), 32'(o_t_we), 32'(v.we));
        chk($sformatf("%s c%0d t_wdata", tag, c), o_t_wdata, v.wdata);
        chk($sformatf("%s c%0d t_be", tag, c), 32'(o_t_be), 32'(v.be));
      end
      if (c == v.exp_lat) begin
        chk($sformatf("%s rsp_rdata", tag), o_rsp_rdata, v.exp_rdata);
        chk($sformatf("%s rsp_err", tag), 32'(o_rsp_err), 32'(v.exp_err));
      end
      rd = {$urandom, $urandom, $urandom};
      if (m != 0) rd[v.exp_tgt*32 +: 32] = v.rdata;
      i_t_rdata = rd;
      i_t_ready = (c == 1 + v.rdly) ? m : (3'($urandom) & ~m);
      sel_rv = (c <= 1 + v.rdly) ? (m & 3'($urandom)) : (c == 2 + v.rdly + v.sdly) ? m : 3'b000;
      i_t_rsp_valid = sel_rv | (v.stray ? ~m : (3'($urandom) & ~m));
      @(negedge i_clk);
    end
    chk($sformatf("%s after rsp_valid", tag), 32'(o_rsp_valid), 32'd0);
    chk($sformatf("%s after rdata held", tag), o_rsp_rdata, v.exp_rdata);
    chk($sformatf("%s after err held", tag), 32'(o_rsp_err), 32'(v.exp_err));
    i_t_ready = 3'b000; i_t_rsp_valid = 3'b000;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_we = 1'b0;
    i_req_wdata = '0; i_req_be = '0; i_t_ready = '0; i_t_rsp_valid = '0; i_t_rdata = '0;
    tbl[0]  = mk(32'h0000_0100, 0, 32'h0,         4'hF, 0, 0, 32'hAAAA_AAAA, 0, 0, 3, 0, 32'hAAAA_AAAA);
    tbl[1]  = mk(32'h1000_0004, 1, 32'h5555_5555, 4'h3, 4, 0, 32'hDEAD_BEEF, 0, 1, 7, 0, 32'h0);
    tbl[2]  = mk(32'h3000_0000, 0, 32'h0,         4'hF, 0, 0, 32'h1111_1111, 0, 3, 1, 1, 32'h0);
    tbl[3]  = mk(32'h2000_0008, 0, 32'h0,         4'hF, 0, 3, 32'hA76A_BC43, 1, 2, 6, 0, 32'hA76A_BC43);
    tbl[4]  = mk(32'h0000_3FFC, 0, 32'h0,         4'hF, 1, 1, 32'h1234_5678, 0, 0, 5, 0, 32'h1234_5678);
    tbl[5]  = mk(32'h0000_4000, 0, 32'h0,         4'hF, 0, 0, 32'h2222_2222, 0, 3, 1, 1, 32'h0);
    tbl[6]  = mk(32'h1000_00FC, 0, 32'h0,         4'hF, 0, 2, 32'hCAFE_F00D, 1, 1, 5, 0, 32'hCAFE_F00D);
    tbl[7]  = mk(32'h1000_0100, 1, 32'h7777_7777, 4'h1, 0, 0, 32'h3333_3333, 0, 3, 1, 1, 32'h0);
    tbl[8]  = mk(32'h2000_000F, 1, 32'h0BAD_F00D, 4'h8, 2, 1, 32'h4444_4444, 0, 2, 6, 0, 32'h0);
    tbl[9]  = mk(32'h2000_0010, 0, 32'h0,         4'hF, 0, 0, 32'h5555_5555, 0, 3, 1, 1, 32'h0);
    tbl[10] = mk(32'h0000_0000, 0, 32'h0,         4'hF, 3, 3, 32'h8000_0001, 1, 0, 9, 0, 32'h8000_0001);
    repeat (2) @(negedge i_clk);
    chk("reset t_valid", 32'(o_t_valid), 32'd0);
    chk("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(o_rsp_err), 32'd0);
    chk("reset req_ready", 32'(o_req_ready), 32'd1);
    chk("reset t_addr", o_t_addr, 32'd0);
    chk("reset t_wdata", o_t_wdata, 32'd0);
    chk("reset t_be", 32'(o_t_be), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 60; i++) run_vec(rand_vec(), $sformatf("rnd%0d", i));

    // abort during ISSUE: valid must drop as soon as reset asserts
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0040; i_req_we = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("abort issue t_valid before", 32'(o_t_valid), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort issue t_valid", 32'(o_t_valid), 32'd0);
    chk("abort issue rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort issue req_ready", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    // abort during WAIT, then a late response must not surface
    i_req_valid = 1'b1; i_req_addr = 32'h1000_0010; i_req_we = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_t_ready = 3'b010;
    @(negedge i_clk);
    i_t_ready = 3'b000;
    chk("abort wait t_valid before", 32'(o_t_valid), 32'd0);
    chk("abort wait req_ready before", 32'(o_req_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("abort wait t_valid", 32'(o_t_valid), 32'd0);
    chk("abort wait rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort wait req_ready", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_t_rsp_valid = 3'b111;
    @(negedge i_clk);
    chk("post-reset late rsp", 32'(o_rsp_valid), 32'd0);
    chk("post-reset req_ready", 32'(o_req_ready), 32'd1);
    i_t_rsp_valid = 3'b000;
    @(negedge i_clk);
    chk("post-reset no rsp", 32'(o_rsp_valid), 32'd0);
    run_vec(tbl[0], "post-reset");

`ifdef BUS_TIMEOUT_EN
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0200; i_req_we = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("timeout c%0d t_valid", c), 32'(o_t_valid), (c <= 16) ? 32'd1 : 32'd0);
      chk($sformatf("timeout c%0d rsp_valid", c), 32'(o_rsp_valid), 32'(c == 17));
      @(negedge i_clk);
    end
    chk("timeout err", 32'(o_rsp_err), 32'd1);
    chk("timeout rdata", o_rsp_rdata, 32'd0);
    i_t_rsp_valid = 3'b001;
    @(negedge i_clk);
    i_t_rsp_valid = 3'b000;
    chk("timeout late rsp", 32'(o_rsp_valid), 32'd0);
    chk("timeout req_ready", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    chk("timeout late rsp settle", 32'(o_rsp_valid), 32'd0);
`else
    run_vec(mk(32'h0000_0200, 0, 32'h0, 4'hF, 30, 5, 32'h600D_CAFE, 1, 0, 38, 0, 32'h600D_CAFE),
            "long-wait");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
